// File: rtl/ysyx22041405_if_id_buf_if.sv
// Fetch-to-decode handshake bundle for ysyx22041405_if_id_buf.
// Latency: none, wires only. Backpressure: in_ready toward fetch, out_ready from decode.
// Flush travels with the bundle because it qualifies both sides of the same transfer.
interface ysyx22041405_if_id_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_inst;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_inst;
    logic             flush;

    // Buffer side.
    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst
    );

    // Fetch/decode side.
    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/ysyx22041405_if_id_buf.sv
// Two-entry IF/ID skid buffer (head + skid), strict FIFO order, flush drops everything.
// Latency: 1 cycle from accept to out_valid when empty. Backpressure: in_ready is a decoded state flop, no comb path from out_ready.
// Optional decode-stall counter on perf_stall_cnt when IFID_PERF_EN is defined.
module ysyx22041405_if_id_buf #(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx22041405_if_id_buf_if.slave     bus
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    // Bit 0 = head occupied, bit 1 = skid occupied, so both flags come straight off flops.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_ld_h_in;
    logic             w_ld_h_s;
    logic             w_ld_s;
    logic [WIDTH-1:0] r_h_pc;
    logic [WIDTH-1:0] r_h_inst;
    logic [WIDTH-1:0] r_s_pc;
    logic [WIDTH-1:0] r_s_inst;

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_h_in   = 1'b0;
        w_ld_h_s    = 1'b0;
        w_ld_s      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_ld_h_in   = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld_h_in   = 1'b1;
                    end else if (w_in_fire) begin
                        w_ld_s      = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_fire) begin
                        w_ld_h_s    = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_in_ready  = ~r_state[1];
        w_out_valid = r_state[0];
    end

    // Payloads are left untouched by flush; only the state forgets them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_pc   <= '0;
            r_h_inst <= '0;
            r_s_pc   <= '0;
            r_s_inst <= '0;
        end else begin
            if (w_ld_h_in) begin
                r_h_pc   <= bus.in_pc;
                r_h_inst <= bus.in_inst;
            end else if (w_ld_h_s) begin
                r_h_pc   <= r_s_pc;
                r_h_inst <= r_s_inst;
            end
            if (w_ld_s) begin
                r_s_pc   <= bus.in_pc;
                r_s_inst <= bus.in_inst;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = r_h_pc;
    assign bus.out_inst  = r_h_inst;

`ifdef IFID_PERF_EN
    logic [31:0] r_stall_cnt;

    // Free-running wrap; flush deliberately does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
